// File: rtl/mac_pipe.sv
// mac_pipe: three-stage multiply-accumulate pipeline with valid/ready handshakes.
// S1 captures the operands, S2 holds the product, S3 holds the saturated result
// and owns the running accumulator. One global stall freezes every stage.
module mac_pipe #(
    parameter int WIDTH = 8,
    parameter int GUARD = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [WIDTH-1:0]           c,
    input  logic                       mode,
    input  logic                       acc_load,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*WIDTH+GUARD-1:0]   data_out,
    output logic                       ovf
);

    localparam int OUT_W  = 2*WIDTH + GUARD;
    localparam int PROD_W = 2*WIDTH;

    // Clamp a sum that spilled into bit OUT_W to all ones. The top bit of the
    // returned vector is the overflow flag, the remaining bits the result.
    // The widest sum (accumulator + product) always fits in OUT_W+1 bits, so
    // that single carry bit is enough to detect saturation.
    function automatic logic [OUT_W:0] saturate(input logic [OUT_W:0] sum);
        logic [OUT_W:0] res;
        if (sum[OUT_W]) begin
            res = {1'b1, {OUT_W{1'b1}}};
        end else begin
            res = {1'b0, sum[OUT_W-1:0]};
        end
        return res;
    endfunction

    // Stage 1 registers
    logic              s1_valid_r;
    logic [WIDTH-1:0]  s1_a_r;
    logic [WIDTH-1:0]  s1_b_r;
    logic [WIDTH-1:0]  s1_c_r;
    logic              s1_mode_r;
    logic              s1_load_r;

    // Stage 2 registers
    logic              s2_valid_r;
    logic [PROD_W-1:0] s2_prod_r;
    logic [WIDTH-1:0]  s2_c_r;
    logic              s2_mode_r;
    logic              s2_load_r;

    // Stage 3 registers (drive the outputs directly)
    logic              s3_valid_r;
    logic [OUT_W-1:0]  s3_data_r;
    logic              s3_ovf_r;
    logic [OUT_W-1:0]  acc_r;

    // Combinational helpers
    logic              stall_s;
    logic [OUT_W:0]    sum_s;
    logic [OUT_W:0]    sat_s;

    // The whole pipe freezes while a result is waiting on downstream.
    assign stall_s  = s3_valid_r && !out_ready;
    assign in_ready = !stall_s;

    assign out_valid = s3_valid_r;
    assign data_out  = s3_data_r;
    assign ovf       = s3_ovf_r;

    // Stage 1: capture the offered beat; bubbles keep the old operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_c_r     <= {WIDTH{1'b0}};
            s1_mode_r  <= 1'b0;
            s1_load_r  <= 1'b0;
        end else if (!stall_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_a_r    <= a;
                s1_b_r    <= b;
                s1_c_r    <= c;
                s1_mode_r <= mode;
                s1_load_r <= acc_load;
            end else begin
                s1_a_r    <= s1_a_r;
                s1_b_r    <= s1_b_r;
                s1_c_r    <= s1_c_r;
                s1_mode_r <= s1_mode_r;
                s1_load_r <= s1_load_r;
            end
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: form the full-width product and forward the addend and controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_r <= 1'b0;
            s2_prod_r  <= {PROD_W{1'b0}};
            s2_c_r     <= {WIDTH{1'b0}};
            s2_mode_r  <= 1'b0;
            s2_load_r  <= 1'b0;
        end else if (!stall_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_prod_r <= PROD_W'(s1_a_r) * PROD_W'(s1_b_r);
                s2_c_r    <= s1_c_r;
                s2_mode_r <= s1_mode_r;
                s2_load_r <= s1_load_r;
            end else begin
                s2_prod_r <= s2_prod_r;
                s2_c_r    <= s2_c_r;
                s2_mode_r <= s2_mode_r;
                s2_load_r <= s2_load_r;
            end
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // Select the addend: accumulate beats add the running total, all others add c.
    always_comb begin
        sum_s = {(OUT_W+1){1'b0}};
        if (s2_mode_r && !s2_load_r) begin
            sum_s = {1'b0, acc_r} + {{(OUT_W+1-PROD_W){1'b0}}, s2_prod_r};
        end else begin
            sum_s = {{(OUT_W+1-PROD_W){1'b0}}, s2_prod_r}
                  + {{(OUT_W+1-WIDTH){1'b0}}, s2_c_r};
        end
        sat_s = saturate(sum_s);
    end

    // Stage 3: register the saturated result; accumulate beats also update the
    // accumulator on the same edge, so the next accumulate beat sees it at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            s3_valid_r <= 1'b0;
            s3_data_r  <= {OUT_W{1'b0}};
            s3_ovf_r   <= 1'b0;
            acc_r      <= {OUT_W{1'b0}};
        end else if (!stall_s) begin
            s3_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                s3_data_r <= sat_s[OUT_W-1:0];
                s3_ovf_r  <= sat_s[OUT_W];
                if (s2_mode_r) begin
                    acc_r <= sat_s[OUT_W-1:0];
                end else begin
                    acc_r <= acc_r;
                end
            end else begin
                s3_data_r <= s3_data_r;
                s3_ovf_r  <= s3_ovf_r;
                acc_r     <= acc_r;
            end
        end else begin
            s3_valid_r <= s3_valid_r;
            s3_data_r  <= s3_data_r;
            s3_ovf_r   <= s3_ovf_r;
            acc_r      <= acc_r;
        end
    end

endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: directed, table-driven bench for mac_pipe (WIDTH=8, GUARD=4).
// Inputs change 1 time unit after posedge; outputs are sampled then or at negedge.
module tb_mac_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a, b, c;
    logic        mode;
    logic        acc_load;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] data_out;
    logic        ovf;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        mode;
        logic        load;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  c;
        logic [19:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    localparam int NT = 11;
    vec_t tbl[NT];
    vec_t sq[20];

    mac_pipe #(.WIDTH(8), .GUARD(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c        (c),
        .mode     (mode),
        .acc_load (acc_load),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Hard stop in case anything wedges.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        mode     = v.mode;
        acc_load = v.load;
        a        = v.a;
        b        = v.b;
        c        = v.c;
    endtask

    function automatic vec_t mk(input logic m, input logic l, input logic [7:0] aa,
                                input logic [7:0] bb, input logic [7:0] cc,
                                input logic [19:0] e, input logic o);
        vec_t v;
        v.mode = m; v.load = l; v.a = aa; v.b = bb; v.c = cc;
        v.exp_data = e; v.exp_ovf = o;
        return v;
    endfunction

    // Stream sq[0..n-1] honouring in_ready; optionally hold out_ready low for
    // stall_len cycles starting in the cycle the first result appears.
    task automatic run_stream(input int n, input int stall_len, input string tag);
        int j = 0;
        int k = 0;
        int stall_cnt = 0;
        bit stalled_once = 1'b0;
        int extra = 0;
        for (int cyc = 0; cyc < 80 && k < n; cyc++) begin
            @(posedge clk); #1;
            if (!stalled_once && out_valid && stall_len > 0) begin
                stall_cnt    = stall_len;
                stalled_once = 1'b1;
            end
            out_ready = (stall_cnt == 0);
            if (stall_cnt > 0) stall_cnt--;
            if (j < n) drive(sq[j]);
            else in_valid = 1'b0;
            @(negedge clk);
            if (out_valid && out_ready) begin
                check({tag, "_data"}, 32'(data_out), 32'(sq[k].exp_data));
                check({tag, "_ovf"},  32'(ovf),      32'(sq[k].exp_ovf));
                k++;
            end else if (out_valid) begin
                check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
                check({tag, "_stall_hold"},     32'(data_out), 32'(sq[k].exp_data));
            end
            if (in_valid && in_ready) j++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_count"}, 32'(k), 32'(n));
        repeat (5) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check({tag, "_no_extra"}, 32'(extra), 32'd0);
    endtask

    initial begin
        int stale;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = 8'd0; b = 8'd0; c = 8'd0; mode = 1'b0; acc_load = 1'b0;

        // Table: applied back-to-back starting from a freshly reset accumulator.
        tbl[0]  = mk(1'b1, 1'b0,   8'd2,   8'd3,   8'd0,      20'd6, 1'b0); // acc starts at 0
        tbl[1]  = mk(1'b0, 1'b0, 8'd255, 8'd255, 8'd255,  20'd65280, 1'b0);
        tbl[2]  = mk(1'b1, 1'b0,   8'd1,   8'd4,  8'd99,     20'd10, 1'b0); // c ignored
        tbl[3]  = mk(1'b1, 1'b1,  8'd10,  8'd10,   8'd5,    20'd105, 1'b0); // load
        tbl[4]  = mk(1'b1, 1'b0,   8'd3,   8'd4,  8'd77,    20'd117, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0,   8'd1,   8'd2,   8'd3,      20'd5, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0,   8'd1,   8'd1,   8'd0,    20'd118, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1,   8'd0,   8'd0,   8'd0,      20'd0, 1'b0);
        tbl[8]  = mk(1'b1, 1'b1,   8'd0,   8'd0,   8'd7,      20'd7, 1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 8'd255, 8'd255,   8'd0,  20'd65025, 1'b0);
        tbl[10] = mk(1'b1, 1'b0,   8'd0,   8'd0,   8'd0,      20'd7, 1'b0);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_data_out",  32'(data_out),  32'd0);
        check("reset_ovf",       32'(ovf),       32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd1);

        // Fixed 3-cycle latency, one beat per cycle, then a trailing bubble.
        for (int i = 0; i <= NT + 3; i++) begin
            @(posedge clk); #1;
            if (i < NT) drive(tbl[i]);
            else in_valid = 1'b0;
            if (i >= 3 && i - 3 < NT) begin
                check($sformatf("tbl%0d_valid", i-3), 32'(out_valid), 32'd1);
                check($sformatf("tbl%0d_data", i-3),  32'(data_out),  32'(tbl[i-3].exp_data));
                check($sformatf("tbl%0d_ovf", i-3),   32'(ovf),       32'(tbl[i-3].exp_ovf));
            end else if (i >= 3) begin
                check("bubble_valid", 32'(out_valid), 32'd0);
                check("bubble_data",  32'(data_out),  32'(tbl[NT-1].exp_data));
            end else begin
                check("fill_valid", 32'(out_valid), 32'd0);
            end
        end

        // Saturating accumulation: load 65025 then keep adding 65025.
        sq[0] = mk(1'b1, 1'b1, 8'd255, 8'd255, 8'd0, 20'd65025, 1'b0);
        for (int k = 1; k < 18; k++) begin
            if (k < 16) sq[k] = mk(1'b1, 1'b0, 8'd255, 8'd255, 8'd0, 20'(65025 * (k + 1)), 1'b0);
            else        sq[k] = mk(1'b1, 1'b0, 8'd255, 8'd255, 8'd0, 20'd1048575, 1'b1);
        end
        run_stream(18, 0, "sat");

        // Backpressure: five beats, downstream stalls four cycles.
        sq[0] = mk(1'b0, 1'b0,   8'd1, 8'd1,  8'd1,   20'd2, 1'b0);
        sq[1] = mk(1'b0, 1'b0,   8'd2, 8'd3,  8'd0,   20'd6, 1'b0);
        sq[2] = mk(1'b0, 1'b0,  8'd10, 8'd10, 8'd10, 20'd110, 1'b0);
        sq[3] = mk(1'b0, 1'b0, 8'd200, 8'd2,  8'd1,  20'd401, 1'b0);
        sq[4] = mk(1'b0, 1'b0,   8'd0, 8'd0,  8'd9,   20'd9, 1'b0);
        run_stream(5, 4, "stall");

        // Reset with two beats in flight; the accumulator is nonzero beforehand.
        @(posedge clk); #1;
        drive(mk(1'b1, 1'b1, 8'd5, 8'd5, 8'd1, 20'd0, 1'b0));
        @(posedge clk); #1;
        drive(mk(1'b1, 1'b0, 8'd5, 8'd5, 8'd0, 20'd0, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_reset_out_valid", 32'(out_valid), 32'd0);
        check("mid_reset_data_out",  32'(data_out),  32'd0);
        check("mid_reset_ovf",       32'(ovf),       32'd0);
        check("mid_reset_in_ready",  32'(in_ready),  32'd1);
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("mid_reset_no_stale", 32'(stale), 32'd0);
        sq[0] = mk(1'b1, 1'b0, 8'd2, 8'd3, 8'd0, 20'd6, 1'b0);
        run_stream(1, 0, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_pipe.md
MAC_PIPE -- requirements
Module: mac_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand width of a, b and c (unsigned).
REQ-002 Parameter GUARD, default 4: accumulator guard bits; OUT_W = 2*WIDTH+GUARD.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 in_valid  in  1  input beat offered.
REQ-006 in_ready  out  1  block accepts the beat this cycle.
REQ-007 a, b, c  in  WIDTH each  operands.
REQ-008 mode  in  1  0 = single a*b+c; 1 = accumulate.
REQ-009 acc_load  in  1  mode 1 only: restart accumulator from a*b+c.
REQ-010 out_valid  out  1  result beat present.
REQ-011 out_ready  in  1  downstream accepts the result beat.
REQ-012 data_out  out  OUT_W  result.
REQ-013 ovf  out  1  saturation occurred on this result beat.

Function
REQ-014 A beat transfers in when in_valid && in_ready; a result transfers out when out_valid && out_ready.
REQ-015 Three-stage pipeline: S1 registers a, b, c, mode, acc_load; S2 registers product a*b (2*WIDTH bits) and c; S3 registers the add/accumulate result.
REQ-016 No stall: result of an accepted beat appears on data_out exactly 3 cycles after acceptance; throughput 1 beat/cycle.
REQ-017 Global stall condition: out_valid && !out_ready; while stalled, S1-S3 and the accumulator hold their contents.
REQ-018 in_ready = !stall, combinational; beats are neither lost nor duplicated under backpressure.
REQ-019 Each stage carries a valid bit; bubbles propagate without changing data_out, accumulator or ovf.
REQ-020 mode 0: sum = product + c, zero-extended to OUT_W+1 bits; accumulator unchanged.
REQ-021 mode 1, acc_load=1: sum = product + c; accumulator <= result.
REQ-022 mode 1, acc_load=0: sum = accumulator + product (c ignored); accumulator <= result.
REQ-023 Saturation: if sum > 2^OUT_W-1, result = 2^OUT_W-1 (all ones) and ovf=1 for that beat; else result = sum, ovf=0.
REQ-024 After saturation in mode 1, the accumulator holds all ones; further mode-1 beats without acc_load keep saturating with ovf=1.
REQ-025 Accumulator updates in S3 in beat order; back-to-back mode-1 beats see the value written by the immediately preceding mode-1 beat (no hazard bubble).
REQ-026 Interleaved mode-0 beats neither read nor disturb the accumulator.
REQ-027 data_out and ovf hold their values while out_valid=1 and out_ready=0.
REQ-028 in_valid=0 with in_ready=1 inserts a bubble; out_valid drops 3 cycles later unless a stall intervenes.

Reset
REQ-029 While reset=1 at posedge clk: all stage valid bits, out_valid, ovf, data_out and accumulator <= 0.
REQ-030 Reset mid-operation discards all in-flight beats; no result from a pre-reset beat appears after reset.
REQ-031 in_ready = 1 in the first cycle after reset deasserts; the accumulator starts at 0 (mode 1 without acc_load then adds to 0).

Verification (WIDTH=8, GUARD=4, OUT_W=20, out_ready=1 unless stated)
REQ-032 mode 0, a=255, b=255, c=255 accepted at cycle T -> data_out=65280, ovf=0, out_valid=1 at T+3.
REQ-033 mode 1: (10,10,5,load=1) then (3,4,x,load=0) back-to-back -> results 105, then 117 on consecutive cycles.
REQ-034 mode 1: load (255,255,0) then 16 beats (255,255,load=0) -> 17th result 1048575 with ovf=1, all prior results exact with ovf=0; an 18th beat -> 1048575, ovf=1.
REQ-035 5 beats streamed, out_ready=0 for 4 cycles starting when the first result appears -> data_out held, in_ready=0 during the stall, all 5 results delivered in order with no loss or duplication.
REQ-036 reset=1 for 1 cycle with 2 beats in flight -> out_valid=0, data_out=0, ovf=0 next cycle; a subsequent mode-1 beat (2,3,load=0) -> result 6.
